// File: rtl/wisc_lane_pkg.sv
// wisc_lane_pkg
// Shared definitions for the WISC lane-serial datapath: lane mode encoding,
// lane counts per mode, the serializer state type, and a helper returning
// the index of the final lane for a given mode.
package wisc_lane_pkg;

    localparam logic MODE_BYTE   = 1'b0;
    localparam logic MODE_NIBBLE = 1'b1;

    localparam int unsigned BYTE_LANES   = 32'd2;
    localparam int unsigned NIBBLE_LANES = 32'd4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Index of the final lane of a word in the given mode.
    function automatic logic [1:0] last_lane(input logic mode);
        logic [1:0] idx;
        if (mode == MODE_NIBBLE) begin
            idx = 2'(NIBBLE_LANES - 32'd1);
        end else begin
            idx = 2'(BYTE_LANES - 32'd1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lane_sext.sv
// lane_sext
// Combinational lane extractor: selects one lane of a 16-bit word and
// sign-extends it to 16 bits. Shared with the reduction datapath.
//   word     : source word
//   mode     : MODE_BYTE (2 x 8-bit lanes) or MODE_NIBBLE (4 x 4-bit lanes)
//   lane     : lane index, 0 = least significant (bit 1 ignored in byte mode)
//   lane_val : selected lane, sign-extended
module lane_sext
    import wisc_lane_pkg::*;
(
    input  logic [15:0] word,
    input  logic        mode,
    input  logic [1:0]  lane,
    output logic [15:0] lane_val
);

    logic [7:0] byte_s;
    logic [3:0] nib_s;

    // Lane select and sign extension for both modes.
    always_comb begin
        byte_s   = 8'h00;
        nib_s    = 4'h0;
        lane_val = 16'h0000;
        if (mode == MODE_NIBBLE) begin
            case (lane)
                2'd0:    nib_s = word[3:0];
                2'd1:    nib_s = word[7:4];
                2'd2:    nib_s = word[11:8];
                2'd3:    nib_s = word[15:12];
                default: nib_s = 4'h0;
            endcase
            lane_val = {{12{nib_s[3]}}, nib_s};
        end else begin
            case (lane[0])
                1'b0:    byte_s = word[7:0];
                1'b1:    byte_s = word[15:8];
                default: byte_s = 8'h00;
            endcase
            lane_val = {{8{byte_s[7]}}, byte_s};
        end
    end

endmodule

// File: rtl/byte_lane_serializer.sv
// byte_lane_serializer
// Accepts a 16-bit register word over a valid/ready handshake and emits its
// signed lanes one per cycle (LSB lane first), each sign-extended to 16 bits.
// After the last lane it pulses sum_valid with the signed sum of all lanes.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : word handshake; in_data word, in_mode lane mode
//   out_valid/out_ready   : lane handshake; out_data lane, out_lane index,
//                           out_last marks the final lane of the word
//   sum_valid/sum_data    : one-cycle pulse with the completed word's lane sum
//   busy                  : a word is being held
module byte_lane_serializer
    import wisc_lane_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [1:0]        out_lane,
    output logic              out_last,
    output logic              sum_valid,
    output logic [WORD_W-1:0] sum_data,
    output logic              busy
);

    state_e            state_r;
    state_e            state_next_s;
    logic [WORD_W-1:0] word_r;
    logic              mode_r;
    logic [1:0]        lane_r;
    logic [WORD_W-1:0] out_data_r;
    logic              out_last_r;
    logic [WORD_W-1:0] acc_r;
    logic              sum_valid_r;
    logic [WORD_W-1:0] sum_data_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              lane_hs_s;
    logic              last_hs_s;
    logic [WORD_W-1:0] sel_word_s;
    logic              sel_mode_s;
    logic [1:0]        sel_lane_s;
    logic [WORD_W-1:0] sext_s;

    assign out_valid = (state_r == SEND);
    assign busy      = (state_r == SEND);
    assign out_data  = out_data_r;
    assign out_lane  = lane_r;
    assign out_last  = out_last_r;
    assign sum_valid = sum_valid_r;
    assign sum_data  = sum_data_r;
    assign in_ready  = in_ready_s;

    assign lane_hs_s = out_valid & out_ready;
    assign last_hs_s = lane_hs_s & out_last_r;
    assign accept_s  = in_valid & in_ready_s;

    // Upstream ready: open in IDLE, or in SEND on the final lane handshake so
    // a following word can enter without a bubble.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                SEND:    in_ready_s = last_hs_s;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    // The single extractor serves both the newly accepted word (lane 0) and
    // the next lane of the held word.
    always_comb begin
        sel_word_s = word_r;
        sel_mode_s = mode_r;
        sel_lane_s = lane_r + 2'd1;
        if (accept_s) begin
            sel_word_s = in_data;
            sel_mode_s = in_mode;
            sel_lane_s = 2'd0;
        end else begin
            sel_word_s = word_r;
            sel_mode_s = mode_r;
            sel_lane_s = lane_r + 2'd1;
        end
    end

    lane_sext u_lane_sext (
        .word     (sel_word_s),
        .mode     (sel_mode_s),
        .lane     (sel_lane_s),
        .lane_val (sext_s)
    );

    // Next-state logic for the IDLE/SEND controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (last_hs_s && !accept_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Hold register, lane presentation, accumulator and sum publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r      <= '0;
            mode_r      <= MODE_BYTE;
            lane_r      <= 2'd0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            acc_r       <= '0;
            sum_valid_r <= 1'b0;
            sum_data_r  <= '0;
        end else begin
            // The old word's sum is published even when a new word is
            // accepted on the same edge.
            if (last_hs_s) begin
                sum_valid_r <= 1'b1;
                sum_data_r  <= acc_r + out_data_r;
            end else begin
                sum_valid_r <= 1'b0;
            end

            if (accept_s) begin
                word_r     <= in_data;
                mode_r     <= in_mode;
                lane_r     <= 2'd0;
                out_data_r <= sext_s;
                out_last_r <= 1'b0;
                acc_r      <= '0;
            end else if (last_hs_s) begin
                lane_r     <= 2'd0;
                out_data_r <= '0;
                out_last_r <= 1'b0;
                acc_r      <= '0;
            end else if (lane_hs_s) begin
                lane_r     <= sel_lane_s;
                out_data_r <= sext_s;
                out_last_r <= (sel_lane_s == last_lane(mode_r));
                acc_r      <= acc_r + out_data_r;
            end else begin
                lane_r     <= lane_r;
                out_data_r <= out_data_r;
                out_last_r <= out_last_r;
                acc_r      <= acc_r;
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_serializer.sv
// tb_byte_lane_serializer
// Scoreboard bench: each accepted word pushes its expected lanes and sum,
// computed arithmetically from the word, into queues; a monitor pops and
// compares whenever a lane handshake or sum pulse is seen.
module tb_byte_lane_serializer;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  l;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        sum_valid;
    logic [15:0] sum_data;
    logic        busy;

    exp_t        lane_q[$];
    logic [15:0] sum_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    byte_lane_serializer #(.WORD_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .sum_valid (sum_valid),
        .sum_data  (sum_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: split the word into signed lanes by plain arithmetic.
    function automatic void push_word(input logic [15:0] w, input logic m);
        int   nl;
        int   wd;
        int   sum;
        int   v;
        exp_t e;
        nl  = m ? 4 : 2;
        wd  = m ? 4 : 8;
        sum = 0;
        for (int k = 0; k < nl; k++) begin
            v = (int'(w) >> (wd * k)) & ((1 << wd) - 1);
            if (v >= (1 << (wd - 1))) v = v - (1 << wd);
            sum    = sum + v;
            e.d    = 16'(v);
            e.l    = 2'(k);
            e.last = (k == nl - 1);
            lane_q.push_back(e);
        end
        sum_q.push_back(16'(sum));
    endfunction

    // One clock: drive inputs just after the edge, record an accept at negedge.
    task automatic cyc(input logic r, input logic v, input logic [15:0] d,
                       input logic m, input logic rdy);
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = rdy;
        @(negedge clk);
        if (!rst && in_valid && in_ready) push_word(in_data, in_mode);
    endtask

    // Monitor: scoreboard pops, hold-rule and busy consistency checks.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [1:0]  prev_lane;
    logic        prev_last;
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] s;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("busy_vs_out_valid", {31'd0, busy}, {31'd0, out_valid});
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {16'd0, out_data}, {16'd0, prev_data});
                chk("hold_lane", {30'd0, out_lane}, {30'd0, prev_lane});
                chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (lane_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lane_unexpected: got lane data 0x%0h, expected no lane", out_data);
                end else begin
                    e = lane_q.pop_front();
                    chk("lane_data", {16'd0, out_data}, {16'd0, e.d});
                    chk("lane_index", {30'd0, out_lane}, {30'd0, e.l});
                    chk("lane_last", {31'd0, out_last}, {31'd0, e.last});
                end
            end
            if (sum_valid) begin
                if (sum_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sum_unexpected: got sum 0x%0h, expected no sum pulse", sum_data);
                end else begin
                    s = sum_q.pop_front();
                    chk("sum_data", {16'd0, sum_data}, {16'd0, s});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_lane  = out_lane;
            prev_last  = out_last;
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_mode = 1'b0; out_ready = 1'b0;

        // Reset state.
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Byte mode 0x807F, then nibble mode 0x7F12.
        cyc(1'b0, 1'b1, 16'h807F, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h7F12, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Backpressure on lane 1 of byte word 0x1234.
        cyc(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            chk("bp_data", {16'd0, out_data}, 32'h0012);
            chk("bp_lane", {30'd0, out_lane}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_no_sum", {31'd0, sum_valid}, 32'd0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Back-to-back words 0x0101 and 0xFFFF.
        cyc(1'b0, 1'b1, 16'h0101, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        chk("b2b_valid_l0", {31'd0, out_valid}, 32'd1);
        cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        chk("b2b_valid_l1", {31'd0, out_valid}, 32'd1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("b2b_valid_w2l0", {31'd0, out_valid}, 32'd1);
        chk("b2b_sum_pulse", {31'd0, sum_valid}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset while lane 1 of a nibble word is presented.
        cyc(1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        lane_q.delete();
        sum_q.delete();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {16'd0, out_data}, 32'd0);
        chk("mid_rst_out_lane", {30'd0, out_lane}, 32'd0);
        chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("mid_rst_sum_data", {16'd0, sum_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready_after", {31'd0, in_ready}, 32'd1);

        // Mode sampled only at accept.
        cyc(1'b0, 1'b1, 16'h00F0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        chk("mode_sample_idle", {31'd0, busy}, 32'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) != 0));
        end

        // Drain with a bounded cycle budget.
        for (int i = 0; i < 40 && (lane_q.size() != 0 || sum_q.size() != 0); i++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("drain_lanes_left", 32'(lane_q.size()), 32'd0);
        chk("drain_sums_left", 32'(sum_q.size()), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
